nonce_result_scanner: RTL and testbench
=======================================

Name: nonce_result_scanner

Overview:
- Downstream stage of the 16-nonce bitcoin hash engine.
- After the engine has written its per-nonce final H0 words to memory, this block reads those words back and compares each one (unsigned) against a difficulty target.
- Reports the first winning nonce, the hit count and the minimum hash, and writes a 3-word summary record back to memory.
- Shares the engine's testbench memory port protocol: synchronous memory, 1-cycle read latency.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words to scan (legal 1..256).

Ports:
- clk  in  1  clock; mem_clk is driven from it.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- result_addr  in  16  base address of hash word for nonce 0.
- summary_addr  in  16  base address of the 3-word summary record.
- target  in  32  difficulty threshold; a hit is hash < target (unsigned).
- done  out  1  high exactly when state == IDLE.
- found  out  1  at least one hit in the last scan.
- winner_nonce  out  32  lowest nonce index that hit; 0 if none.
- min_hash  out  32  smallest hash word seen.
- min_nonce  out  32  index of min_hash; lowest index wins ties.
- hit_count  out  16  number of hits.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  data for the address presented on the previous cycle.

Behaviour:
- Reset (asynchronous) values:
  - state IDLE, so done=1.
  - found=0, winner_nonce=0, min_hash=32'hFFFFFFFF, min_nonce=0, hit_count=0.
  - mem_we=0, mem_addr=0, mem_write_data=0.
- Reset asserted mid-scan or mid-write aborts immediately. Any partial summary already in memory stays as-is; no cleanup.
- States: IDLE -> READ -> DRAIN -> WRITE -> IDLE.
- IDLE:
  - On start=1, latch result_addr, summary_addr and target.
  - Clear found/hit_count/winner_nonce/min_nonce; min_hash=FFFFFFFF; rd_idx=0.
  - Go to READ.
  - start=0 holds IDLE. start while not in IDLE is ignored.
- READ, cycles 1..NUM_NONCES after start:
  - mem_we=0, mem_addr=result_addr+rd_idx (16-bit, wraps modulo 2^16); rd_idx increments.
  - From the 2nd READ cycle onward, mem_read_data belongs to index rd_idx-1 and is evaluated.
  - After issuing index NUM_NONCES-1, go to DRAIN.
- DRAIN, 1 cycle: evaluate the last index (NUM_NONCES-1). No new address issued.
- Evaluation of word h at index j:
  - If h < target: hit_count++. If found==0, set found=1 and winner_nonce=j.
  - If h < min_hash: min_hash=h, min_nonce=j (strict compare, so ties keep the lower index).
  - target=0: no hits are possible.
  - target=FFFFFFFF: every word except FFFFFFFF is a hit.
- WRITE, 3 cycles, mem_we=1:
  - Cycle 0: mem_addr=summary_addr+0, data = {found, 15'b0, hit_count}.
  - Cycle 1: mem_addr=summary_addr+1, data = winner_nonce.
  - Cycle 2: mem_addr=summary_addr+2, data = min_hash.
  - Then IDLE, with mem_we=0 registered on the IDLE entry.
- Latency:
  - Start sampled at edge 0; done returns high after edge NUM_NONCES+5 (21 cycles for 16 nonces).
  - Result outputs are stable from the done rise until the next accepted start.
- Overlap: if the result and summary regions overlap, memory writes follow the reads, so the scan always sees pre-write data.
- All outputs are registered; no combinational path from mem_read_data to outputs.

Decomposition:
- Shared package bitcoin_pkg holds:
  - the scanner state enum;
  - the default NUM_NONCES constant (shared with the hash engine);
  - summary word offsets SUM_FLAGS=0, SUM_WINNER=1, SUM_MIN=2;
  - the 32-bit bit position of the found flag.
- One natural sub-module: hash_rank_unit, a registered compare/update of hit and min tracking for one word per cycle.
- FSM and memory addressing stay in the top module.

Test Plan:
- Words 0..15 = 32'h1000_0000+j, target=32'h1000_0005 -> found=1, winner_nonce=0, hit_count=5, min_hash=32'h1000_0000, min_nonce=0; memory at summary_addr = 8000_0005, 0, 1000_0000.
- All words = FFFF_FFFF, target=0 -> found=0, hit_count=0, winner_nonce=0, min_hash=FFFF_FFFF, min_nonce=0; summary word0 = 0000_0000.
- Words all 32'h5 except [9]=32'h1 and [12]=32'h1, target=32'h2 -> winner_nonce=9, hit_count=2, min_nonce=9 (tie rule).
- result_addr=16'hFFF8 -> reads addresses FFF8..FFFF then 0000..0007; mem_we=0 throughout READ; done returns high exactly 21 cycles after start.
- reset_n pulsed low during READ cycle 5, then a new start -> outputs return to reset values immediately; the second scan's results are correct and unaffected by the aborted one.
- start held high continuously across two scans -> second scan begins in the cycle after IDLE is re-entered; start pulses during READ/WRITE are ignored.

Source files
------------

// File: rtl/bitcoin_pkg.sv
`default_nettype none
//==============================================================================
// bitcoin_pkg : scanner state encoding, summary record layout, shared constants
// Rev 1.0
//==============================================================================
package bitcoin_pkg;

    localparam int DEFAULT_NUM_NONCES = 16;

    localparam int SUM_FLAGS  = 0;
    localparam int SUM_WINNER = 1;
    localparam int SUM_MIN    = 2;

    localparam int FOUND_BIT  = 31;

    localparam logic [31:0] MIN_HASH_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_READ  = 2'd1,
        SCAN_DRAIN = 2'd2,
        SCAN_WRITE = 2'd3
    } scan_state_e;

    function automatic logic [31:0] pack_flags(input logic found, input logic [15:0] hit_count);
        logic [31:0] w;
        w            = {16'b0, hit_count};
        w[FOUND_BIT] = found;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_result_scanner_if.sv
`default_nettype none
//==============================================================================
// nonce_result_scanner_if : control, result and memory-port bundle of the scanner
// Rev 1.0
//==============================================================================
interface nonce_result_scanner_if;

    logic        start;
    logic [15:0] result_addr;
    logic [15:0] summary_addr;
    logic [31:0] target;

    logic        done;
    logic        found;
    logic [31:0] winner_nonce;
    logic [31:0] min_hash;
    logic [31:0] min_nonce;
    logic [15:0] hit_count;

    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  start, result_addr, summary_addr, target, mem_read_data,
        output done, found, winner_nonce, min_hash, min_nonce, hit_count,
        output mem_clk, mem_we, mem_addr, mem_write_data
    );

    modport master (
        output start, result_addr, summary_addr, target, mem_read_data,
        input  done, found, winner_nonce, min_hash, min_nonce, hit_count,
        input  mem_clk, mem_we, mem_addr, mem_write_data
    );

endinterface
`default_nettype wire

// File: rtl/nonce_result_scanner_rank.sv
`default_nettype none
//==============================================================================
// hash_rank_unit : registered hit / minimum tracking, one hash word per cycle
// Rev 1.0
//==============================================================================
module hash_rank_unit
    import bitcoin_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        clear,
    input  wire logic        eval_en,
    input  wire logic [31:0] hash,
    input  wire logic [31:0] target,
    input  wire logic [31:0] index,
    output logic             found,
    output logic [15:0]      hit_count,
    output logic [31:0]      winner_nonce,
    output logic [31:0]      min_hash,
    output logic [31:0]      min_nonce
);

    logic        found_q,        found_d;
    logic [15:0] hit_count_q,    hit_count_d;
    logic [31:0] winner_nonce_q, winner_nonce_d;
    logic [31:0] min_hash_q,     min_hash_d;
    logic [31:0] min_nonce_q,    min_nonce_d;

    always_comb begin
        found_d        = found_q;
        hit_count_d    = hit_count_q;
        winner_nonce_d = winner_nonce_q;
        min_hash_d     = min_hash_q;
        min_nonce_d    = min_nonce_q;
        if (clear) begin
            found_d        = 1'b0;
            hit_count_d    = 16'd0;
            winner_nonce_d = 32'd0;
            min_hash_d     = MIN_HASH_INIT;
            min_nonce_d    = 32'd0;
        end else if (eval_en) begin
            if (hash < target) begin
                hit_count_d = hit_count_q + 16'd1;
                if (!found_q) begin
                    found_d        = 1'b1;
                    winner_nonce_d = index;
                end
            end
            // Strict compare keeps the earliest index on ties.
            if (hash < min_hash_q) begin
                min_hash_d  = hash;
                min_nonce_d = index;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found_q        <= 1'b0;
            hit_count_q    <= 16'd0;
            winner_nonce_q <= 32'd0;
            min_hash_q     <= MIN_HASH_INIT;
            min_nonce_q    <= 32'd0;
        end else begin
            found_q        <= found_d;
            hit_count_q    <= hit_count_d;
            winner_nonce_q <= winner_nonce_d;
            min_hash_q     <= min_hash_d;
            min_nonce_q    <= min_nonce_d;
        end
    end

    assign found        = found_q;
    assign hit_count    = hit_count_q;
    assign winner_nonce = winner_nonce_q;
    assign min_hash     = min_hash_q;
    assign min_nonce    = min_nonce_q;

endmodule
`default_nettype wire

// File: rtl/nonce_result_scanner.sv
`default_nettype none
//==============================================================================
// nonce_result_scanner : reads per-nonce H0 words, ranks them, writes a summary
// Rev 1.0
//==============================================================================
module nonce_result_scanner
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    nonce_result_scanner_if.slave  bus
);

    localparam int              IDX_W    = 9;
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_NONCES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    scan_state_e       state_q,          state_d;
    logic [IDX_W-1:0]  rd_idx_q,         rd_idx_d;
    logic [1:0]        wr_idx_q,         wr_idx_d;
    logic [15:0]       result_addr_q,    result_addr_d;
    logic [15:0]       summary_addr_q,   summary_addr_d;
    logic [31:0]       target_q,         target_d;
    logic              mem_we_q,         mem_we_d;
    logic [15:0]       mem_addr_q,       mem_addr_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic              done_q,           done_d;

    logic              rank_clear;
    logic              eval_en;
    logic [IDX_W-1:0]  eval_idx;
    logic              found;
    logic [15:0]       hit_count;
    logic [31:0]       winner_nonce;
    logic [31:0]       min_hash;
    logic [31:0]       min_nonce;

    hash_rank_unit u_rank (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (rank_clear),
        .eval_en      (eval_en),
        .hash         (bus.mem_read_data),
        .target       (target_q),
        .index        ({{(32-IDX_W){1'b0}}, eval_idx}),
        .found        (found),
        .hit_count    (hit_count),
        .winner_nonce (winner_nonce),
        .min_hash     (min_hash),
        .min_nonce    (min_nonce)
    );

    // mem_addr is loaded one edge ahead, so rd_idx_q-1 is on the bus and the
    // returning word belongs to rd_idx_q-2.
    always_comb begin
        state_d          = state_q;
        rd_idx_d         = rd_idx_q;
        wr_idx_d         = wr_idx_q;
        result_addr_d    = result_addr_q;
        summary_addr_d   = summary_addr_q;
        target_d         = target_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        rank_clear       = 1'b0;
        eval_en          = 1'b0;
        eval_idx         = rd_idx_q - IDX_W'(2);

        unique case (state_q)
            SCAN_IDLE: begin
                if (bus.start) begin
                    result_addr_d  = bus.result_addr;
                    summary_addr_d = bus.summary_addr;
                    target_d       = bus.target;
                    mem_addr_d     = bus.result_addr;
                    rd_idx_d       = IDX_W'(1);
                    rank_clear     = 1'b1;
                    state_d        = SCAN_READ;
                end
            end
            SCAN_READ: begin
                eval_en = (rd_idx_q >= IDX_W'(2));
                if (rd_idx_q == NUM_IDX) begin
                    state_d = SCAN_DRAIN;
                end else begin
                    mem_addr_d = result_addr_q + {{(16-IDX_W){1'b0}}, rd_idx_q};
                    rd_idx_d   = rd_idx_q + IDX_W'(1);
                end
            end
            SCAN_DRAIN: begin
                eval_en  = 1'b1;
                eval_idx = LAST_IDX;
                wr_idx_d = 2'd0;
                state_d  = SCAN_WRITE;
            end
            SCAN_WRITE: begin
                // The ranking settles at the end of DRAIN, so each record word
                // is loaded from settled values one cycle into WRITE.
                if (wr_idx_q == 2'd3) begin
                    mem_we_d = 1'b0;
                    state_d  = SCAN_IDLE;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = summary_addr_q + {14'b0, wr_idx_q};
                    if (wr_idx_q == 2'(SUM_FLAGS)) begin
                        mem_write_data_d = pack_flags(found, hit_count);
                    end else if (wr_idx_q == 2'(SUM_WINNER)) begin
                        mem_write_data_d = winner_nonce;
                    end else begin
                        mem_write_data_d = min_hash;
                    end
                    wr_idx_d = wr_idx_q + 2'd1;
                end
            end
            default: state_d = SCAN_IDLE;
        endcase

        done_d = (state_d == SCAN_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= SCAN_IDLE;
            rd_idx_q         <= '0;
            wr_idx_q         <= 2'd0;
            result_addr_q    <= 16'd0;
            summary_addr_q   <= 16'd0;
            target_q         <= 32'd0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= 16'd0;
            mem_write_data_q <= 32'd0;
            done_q           <= 1'b1;
        end else begin
            state_q          <= state_d;
            rd_idx_q         <= rd_idx_d;
            wr_idx_q         <= wr_idx_d;
            result_addr_q    <= result_addr_d;
            summary_addr_q   <= summary_addr_d;
            target_q         <= target_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            done_q           <= done_d;
        end
    end

    assign bus.done           = done_q;
    assign bus.found          = found;
    assign bus.winner_nonce   = winner_nonce;
    assign bus.min_hash       = min_hash;
    assign bus.min_nonce      = min_nonce;
    assign bus.hit_count      = hit_count;
    assign bus.mem_clk        = clk;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scanner.sv
`default_nettype none
//==============================================================================
// tb_nonce_result_scanner : vector table, random scans and corner sequences
// Rev 1.0
//==============================================================================
module tb_nonce_result_scanner;

    localparam int NUM = 16;

    logic clk = 1'b0;
    logic reset_n;

    nonce_result_scanner_if bus();

    nonce_result_scanner #(.NUM_NONCES(NUM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    logic        pl_we;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
        bus.mem_read_data <= mem[bus.mem_addr];
    end

    typedef struct {
        int          pat;
        logic [31:0] tgt;
        logic [15:0] ra;
        logic [15:0] sa;
        logic        fnd;
        logic [31:0] win;
        logic [15:0] hits;
        logic [31:0] mh;
        logic [31:0] mn;
    } vec_t;

    vec_t        vt [6];
    logic [31:0] words [NUM];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_pattern(input int pat);
        for (int j = 0; j < NUM; j++) begin
            case (pat)
                0:       words[j] = 32'h1000_0000 + 32'(j);
                1:       words[j] = 32'hFFFF_FFFF;
                2:       words[j] = (j == 9 || j == 12) ? 32'h1 : 32'h5;
                default: words[j] = 32'h20 - 32'(j);
            endcase
        end
    endtask

    task automatic preload(input logic [15:0] ra);
        for (int j = 0; j < NUM; j++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = ra + 16'(j);
            pl_data = words[j];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Expected results straight from the ranking rules over the word list.
    task automatic ref_model(input logic [31:0] tgt, output logic f, output logic [31:0] win,
                             output logic [15:0] hits, output logic [31:0] mh, output logic [31:0] mn);
        int first;
        first = -1;
        hits  = 0;
        mh    = 32'hFFFF_FFFF;
        for (int j = 0; j < NUM; j++) begin
            if (words[j] < tgt) begin
                hits++;
                if (first < 0) first = j;
            end
            if (words[j] < mh) mh = words[j];
        end
        f   = (first >= 0);
        win = (first >= 0) ? 32'(first) : 32'd0;
        mn  = 0;
        for (int j = NUM - 1; j >= 0; j--) if (words[j] == mh) mn = 32'(j);
    endtask

    task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tgt,
                            input bit pulse_mid, output int lat, output bit addr_ok,
                            output int nwr, output bit wr_ok);
        logic [15:0] ea;
        @(negedge clk);
        bus.result_addr  = ra;
        bus.summary_addr = sa;
        bus.target       = tgt;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; addr_ok = 1'b1; nwr = 0; wr_ok = 1'b1;
        while (!bus.done && lat < 200) begin
            lat++;
            if (lat <= NUM) begin
                ea = ra + 16'(lat - 1);
                if (bus.mem_addr !== ea || bus.mem_we !== 1'b0) addr_ok = 1'b0;
            end
            if (bus.mem_we) begin
                ea = sa + 16'(nwr);
                if (bus.mem_addr !== ea || lat != NUM + 3 + nwr) wr_ok = 1'b0;
                nwr++;
            end
            bus.start = pulse_mid && (lat == 3 || lat == NUM + 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_results(input logic [15:0] sa, input logic f, input logic [31:0] win,
                                 input logic [15:0] hits, input logic [31:0] mh, input logic [31:0] mn);
        logic [15:0] a1, a2;
        a1 = sa + 16'd1;
        a2 = sa + 16'd2;
        chk("found",     {31'b0, bus.found}, {31'b0, f});
        chk("winner",    bus.winner_nonce, win);
        chk("hit_count", {16'b0, bus.hit_count}, {16'b0, hits});
        chk("min_hash",  bus.min_hash, mh);
        chk("min_nonce", bus.min_nonce, mn);
        chk("sum_flags", mem[sa], {f, 15'b0, hits});
        chk("sum_win",   mem[a1], win);
        chk("sum_min",   mem[a2], mh);
    endtask

    task automatic full_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tgt,
                             input bit pulse_mid, input logic f, input logic [31:0] win,
                             input logic [15:0] hits, input logic [31:0] mh, input logic [31:0] mn);
        int lat, nwr;
        bit aok, wok;
        preload(ra);
        run_scan(ra, sa, tgt, pulse_mid, lat, aok, nwr, wok);
        chk("latency",   32'(lat), 32'(NUM + 5));
        chk("read_addr", {31'b0, aok}, 32'd1);
        chk("write_seq", {31'b0, wok}, 32'd1);
        chk("write_cnt", 32'(nwr), 32'd3);
        check_results(sa, f, win, hits, mh, mn);
    endtask

    initial begin
        logic        f;
        logic [31:0] win, mh, mn, tgt;
        logic [15:0] hits, ra, sa;
        int          lat, mode;

        vt[0] = '{0, 32'h1000_0005, 16'h0010, 16'h0100, 1'b1, 32'd0, 16'd5,  32'h1000_0000, 32'd0};
        vt[1] = '{1, 32'h0000_0000, 16'h0200, 16'h0300, 1'b0, 32'd0, 16'd0,  32'hFFFF_FFFF, 32'd0};
        vt[2] = '{2, 32'h0000_0002, 16'h0400, 16'h0500, 1'b1, 32'd9, 16'd2,  32'h0000_0001, 32'd9};
        vt[3] = '{0, 32'h1000_0005, 16'hFFF8, 16'h0600, 1'b1, 32'd0, 16'd5,  32'h1000_0000, 32'd0};
        vt[4] = '{1, 32'hFFFF_FFFF, 16'h0700, 16'h0800, 1'b0, 32'd0, 16'd0,  32'hFFFF_FFFF, 32'd0};
        vt[5] = '{3, 32'hFFFF_FFFF, 16'h0900, 16'h0A00, 1'b1, 32'd0, 16'd16, 32'h0000_0011, 32'd15};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.result_addr = 16'd0; bus.summary_addr = 16'd0; bus.target = 32'd0;
        pl_we = 1'b0; pl_addr = 16'd0; pl_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_done",     {31'b0, bus.done}, 32'd1);
        chk("rst_found",    {31'b0, bus.found}, 32'd0);
        chk("rst_min_hash", bus.min_hash, 32'hFFFF_FFFF);
        chk("rst_hits",     {16'b0, bus.hit_count}, 32'd0);
        chk("rst_mem_we",   {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_pattern(vt[i].pat);
            full_scan(vt[i].ra, vt[i].sa, vt[i].tgt, (i % 2) == 1,
                      vt[i].fnd, vt[i].win, vt[i].hits, vt[i].mh, vt[i].mn);
        end

        for (int i = 0; i < 10; i++) begin
            mode = int'($urandom_range(0, 3));
            for (int j = 0; j < NUM; j++)
                words[j] = (mode < 2) ? 32'h100 + 32'($urandom_range(0, 15)) : $urandom;
            case ($urandom_range(0, 3))
                0:       tgt = 32'd0;
                1:       tgt = 32'hFFFF_FFFF;
                2:       tgt = 32'h100 + 32'($urandom_range(0, 16));
                default: tgt = $urandom;
            endcase
            ra = 16'($urandom);
            sa = 16'($urandom);
            ref_model(tgt, f, win, hits, mh, mn);
            full_scan(ra, sa, tgt, $urandom_range(0, 1) == 1, f, win, hits, mh, mn);
        end

        // Abort a scan with reset in READ cycle 5, then rescan other data.
        fill_pattern(0);
        preload(16'h0040);
        @(negedge clk);
        bus.result_addr = 16'h0040; bus.summary_addr = 16'h0C00; bus.target = 32'h1000_0005;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_hits", {16'b0, bus.hit_count}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("abort_done",      {31'b0, bus.done}, 32'd1);
        chk("abort_found",     {31'b0, bus.found}, 32'd0);
        chk("abort_hits",      {16'b0, bus.hit_count}, 32'd0);
        chk("abort_winner",    bus.winner_nonce, 32'd0);
        chk("abort_min_hash",  bus.min_hash, 32'hFFFF_FFFF);
        chk("abort_min_nonce", bus.min_nonce, 32'd0);
        chk("abort_mem_we",    {31'b0, bus.mem_we}, 32'd0);
        chk("abort_mem_addr",  {16'b0, bus.mem_addr}, 32'd0);
        chk("abort_wdata",     bus.mem_write_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        fill_pattern(2);
        full_scan(16'h0D00, 16'h0E00, 32'h2, 1'b0, 1'b1, 32'd9, 16'd2, 32'h1, 32'd9);

        // start held high across two back-to-back scans.
        fill_pattern(1);
        preload(16'h1000);
        @(negedge clk);
        bus.result_addr = 16'h1000; bus.summary_addr = 16'h1100; bus.target = 32'd0;
        bus.start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 200) begin lat++; @(negedge clk); end
        chk("held_lat1", 32'(lat), 32'(NUM + 5));
        @(negedge clk);
        chk("held_restart", {31'b0, bus.done}, 32'd0);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 200) begin lat++; @(negedge clk); end
        chk("held_lat2", 32'(lat), 32'(NUM + 5));
        check_results(16'h1100, 1'b0, 32'd0, 16'd0, 32'hFFFF_FFFF, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
